axil_cmd_master: RTL and testbench

- Byte-stream-to-AXI-lite initiator; the host-side counterpart that drives register-mapped peripherals such as the AES UART slave.
- Parses command frames from an 8-bit AXI-stream (typically a UART RX FIFO) and issues single AXI-lite write or read transactions.
- Returns status and read data as an 8-bit AXI-stream response (typically to a UART TX FIFO).
- Lets an external host configure CR1/CR2/BRR/key registers and move TDR/RDR/EPR/DPR data over a serial link.

---
 rtl/axil_cmd_master_pkg.sv | 10 +
 rtl/axil_cmd_master_if.sv | 22 ++
 rtl/axil_cmd_master_ser.sv | 40 ++++
 rtl/axil_cmd_master.sv | 130 +++++++++++++
 tb/tb_axil_cmd_master.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_cmd_master_pkg.sv
// axil_cmd_pkg: opcodes, status codes and FSM states shared by the command master
package axil_cmd_pkg;
   localparam logic [7:0] OP_WRITE   = 8'h57;
   localparam logic [7:0] OP_READ    = 8'h52;
   localparam logic [7:0] ST_BADOP   = 8'hEE;
   localparam logic [7:0] ST_TIMEOUT = 8'hE0;
   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_WDATA, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_RSP
   } state_e;
endpackage

// File: rtl/axil_cmd_master_if.sv
// taxi_axis_if / taxi_axil_if: byte-stream and AXI-lite bundles used by axil_cmd_master
interface taxi_axis_if #(parameter int DATA_W = 8);
   logic [DATA_W-1:0]   tdata;
   logic [DATA_W/8-1:0] tkeep;
   logic                tvalid, tready, tlast, tid, tdest, tuser;
   modport src (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
   modport snk (input tdata, tvalid, output tready);
endinterface

interface taxi_axil_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
   logic [ADDR_W-1:0]   awaddr, araddr;
   logic [2:0]          awprot, wprot, arprot;
   logic                awvalid, awready, wvalid, wready, bvalid, bready;
   logic [DATA_W-1:0]   wdata, rdata;
   logic [DATA_W/8-1:0] wstrb;
   logic [1:0]          bresp, rresp;
   logic                arvalid, arready, rvalid, rready;
   modport wr_mst (output awaddr, awprot, awvalid, wdata, wstrb, wprot, wvalid, bready,
                   input awready, wready, bresp, bvalid);
   modport rd_mst (output araddr, arprot, arvalid, rready,
                   input arready, rdata, rresp, rvalid);
endinterface

// File: rtl/axil_cmd_master_ser.sv
// axis_byte_serializer: emits up to 5 loaded bytes LSB-first with tlast on the final one
module axis_byte_serializer (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic [39:0] data_i,
   input  logic [2:0]  cnt_i,
   taxi_axis_if.src    m_axis,
   output logic        done_o
);
   logic [39:0] sh_q, sh_d;
   logic [2:0]  rem_q, rem_d;
   logic        vld_q, vld_d, hs, last;
   assign hs   = vld_q & m_axis.tready;
   assign last = rem_q == 3'd1;
   always_comb begin
      sh_d  = load_i ? data_i : hs ? {8'h00, sh_q[39:8]} : sh_q;
      rem_d = load_i ? cnt_i : hs ? rem_q - 3'd1 : rem_q;
      vld_d = load_i | (vld_q & ~(hs & last));
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sh_q  <= '0;
         rem_q <= '0;
         vld_q <= 1'b0;
      end else begin
         sh_q  <= sh_d;
         rem_q <= rem_d;
         vld_q <= vld_d;
      end
   end
   assign m_axis.tvalid = vld_q;
   assign m_axis.tdata  = sh_q[7:0];
   assign m_axis.tlast  = last;
   assign m_axis.tkeep  = '1;
   assign m_axis.tid    = 1'b0;
   assign m_axis.tdest  = 1'b0;
   assign m_axis.tuser  = 1'b0;
   assign done_o        = hs & last;
endmodule

// File: rtl/axil_cmd_master.sv
// axil_cmd_master: parses byte-stream command frames into single AXI-lite reads/writes
module axil_cmd_master
   import axil_cmd_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int GAP_TIMEOUT = 100000
) (
   input  logic         clk_i,
   input  logic         rst_i,
   taxi_axis_if.snk     s_axis_cmd,
   taxi_axis_if.src     m_axis_rsp,
   taxi_axil_if.wr_mst  m_axil_wr,
   taxi_axil_if.rd_mst  m_axil_rd,
   output logic         busy_o
);
   localparam int TW = $clog2(GAP_TIMEOUT + 1);
   state_e            state_q, state_d;
   logic              wr_q, wr_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic [1:0]        bcnt_q, bcnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [TW-1:0]     tmr_q, tmr_d;
   logic              acc, awv, wv, ld, rsp_done;
   logic [2:0]        ld_cnt;
   logic [39:0]       ld_data;
   assign s_axis_cmd.tready = ~rst_i & (state_q inside {S_IDLE, S_ADDR, S_WDATA});
   assign acc = s_axis_cmd.tvalid & s_axis_cmd.tready;
   assign awv = state_q == S_WR_REQ && !aw_done_q;
   assign wv  = state_q == S_WR_REQ && !w_done_q;
   always_comb begin
      state_d   = state_q;
      wr_d      = wr_q;
      bcnt_d    = bcnt_q;
      addr_d    = addr_q;
      data_d    = data_q;
      aw_done_d = aw_done_q | (awv & m_axil_wr.awready);
      w_done_d  = w_done_q | (wv & m_axil_wr.wready);
      tmr_d     = (state_q inside {S_ADDR, S_WDATA}) && !acc ? tmr_q + 1'b1 : '0;
      ld        = 1'b0;
      ld_cnt    = 3'd1;
      ld_data   = {32'h0, ST_BADOP};
      case (state_q)
         S_IDLE: if (acc) begin
            if (s_axis_cmd.tdata == OP_WRITE || s_axis_cmd.tdata == OP_READ) begin
               state_d = S_ADDR;
               wr_d    = s_axis_cmd.tdata == OP_WRITE;
               bcnt_d  = '0;
            end else begin
               state_d = S_RSP;
               ld      = 1'b1;
            end
         end
         S_ADDR, S_WDATA: if (acc) begin
            bcnt_d = bcnt_q + 2'd1;
            if (state_q == S_ADDR) addr_d = {s_axis_cmd.tdata, addr_q[ADDR_W-1:8]};
            else data_d = {s_axis_cmd.tdata, data_q[DATA_W-1:8]};
            if (bcnt_q == 2'd3)
               state_d = state_q == S_WDATA ? S_WR_REQ : wr_q ? S_WDATA : S_RD_REQ;
         end else if (tmr_q == TW'(GAP_TIMEOUT - 1)) begin
            // idle too long mid-frame: drop what was collected and report it
            state_d = S_RSP;
            ld      = 1'b1;
            ld_data = {32'h0, ST_TIMEOUT};
         end
         S_WR_REQ: if (aw_done_d && w_done_d) begin
            state_d   = S_WR_RESP;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
         end
         S_WR_RESP: if (m_axil_wr.bvalid) begin
            state_d = S_RSP;
            ld      = 1'b1;
            ld_data = {32'h0, 6'b0, m_axil_wr.bresp};
         end
         S_RD_REQ: if (m_axil_rd.arready) state_d = S_RD_RESP;
         S_RD_RESP: if (m_axil_rd.rvalid) begin
            state_d = S_RSP;
            ld      = 1'b1;
            ld_cnt  = 3'd5;
            ld_data = {m_axil_rd.rdata, 6'b0, m_axil_rd.rresp};
         end
         S_RSP: if (rsp_done) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         wr_q      <= 1'b0;
         bcnt_q    <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         tmr_q     <= '0;
      end else begin
         state_q   <= state_d;
         wr_q      <= wr_d;
         bcnt_q    <= bcnt_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         tmr_q     <= tmr_d;
      end
   end
   assign m_axil_wr.awaddr  = addr_q;
   assign m_axil_wr.awprot  = 3'b0;
   assign m_axil_wr.awvalid = awv;
   assign m_axil_wr.wdata   = data_q;
   assign m_axil_wr.wstrb   = '1;
   assign m_axil_wr.wprot   = 3'b0;
   assign m_axil_wr.wvalid  = wv;
   assign m_axil_wr.bready  = state_q == S_WR_RESP;
   assign m_axil_rd.araddr  = addr_q;
   assign m_axil_rd.arprot  = 3'b0;
   assign m_axil_rd.arvalid = state_q == S_RD_REQ;
   assign m_axil_rd.rready  = state_q == S_RD_RESP;
   assign busy_o            = state_q != S_IDLE;
   axis_byte_serializer u_ser (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (ld),
      .data_i (ld_data),
      .cnt_i  (ld_cnt),
      .m_axis (m_axis_rsp),
      .done_o (rsp_done)
   );
endmodule

// File: tb/tb_axil_cmd_master.sv
// tb_axil_cmd_master: randomized frames against an AXI-lite slave model and a response model
module tb_axil_cmd_master;
   logic clk = 1'b0, rst = 1'b1, busy;
   int checks = 0, failures = 0;
   int cfg_aw_lat = 0, cfg_w_lat = 0, cfg_ar_lat = 0;
   logic [1:0] cfg_bresp = 2'd0, cfg_rresp = 2'd0;
   logic [31:0] cfg_rdata = '0;
   logic cfg_rhold = 1'b0;
   int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, aw_wait = 0, w_wait = 0, ar_wait = 0;
   logic got_aw = 0, got_w = 0, b_pend = 0, b_drop = 0, r_pend = 0, r_drop = 0;
   logic [31:0] last_awaddr, last_wdata, last_araddr;
   logic [3:0] last_wstrb;
   logic [2:0] last_awprot, last_wprot, last_arprot;
   logic sink_rdy = 1'b1, sink_rnd = 1'b0;
   int stall_at = 99;
   logic [8:0] rsp_q[$];

   taxi_axis_if cmd();
   taxi_axis_if rsp();
   taxi_axil_if axil();

   axil_cmd_master #(.GAP_TIMEOUT(16)) dut (
      .clk_i(clk), .rst_i(rst), .s_axis_cmd(cmd), .m_axis_rsp(rsp),
      .m_axil_wr(axil), .m_axil_rd(axil), .busy_o(busy)
   );

   always #5 clk = ~clk;

   // slave decisions are made on the falling edge; a handshake then happens on the next rising edge
   initial begin
      {axil.awready, axil.wready, axil.bvalid, axil.arready, axil.rvalid} = '0;
      axil.bresp = '0; axil.rresp = '0; axil.rdata = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            {axil.awready, axil.wready, axil.bvalid, axil.arready, axil.rvalid} = '0;
            {got_aw, got_w, b_pend, b_drop, r_pend, r_drop} = '0;
            aw_wait = 0; w_wait = 0; ar_wait = 0;
         end else begin
            if (b_drop) begin axil.bvalid = 0; b_drop = 0; end
            if (b_pend && !axil.bvalid) begin axil.bvalid = 1; axil.bresp = cfg_bresp; b_pend = 0; end
            if (axil.bvalid && axil.bready) b_drop = 1;
            if (r_drop) begin axil.rvalid = 0; r_drop = 0; end
            if (r_pend && !axil.rvalid && !cfg_rhold) begin
               axil.rvalid = 1; axil.rdata = cfg_rdata; axil.rresp = cfg_rresp; r_pend = 0;
            end
            if (axil.rvalid && axil.rready) r_drop = 1;
            if (axil.awvalid) begin
               axil.awready = aw_wait >= cfg_aw_lat; aw_wait++;
               if (axil.awready) begin
                  last_awaddr = axil.awaddr; last_awprot = axil.awprot; aw_cnt++; got_aw = 1; aw_wait = 0;
               end
            end else begin axil.awready = 0; aw_wait = 0; end
            if (axil.wvalid) begin
               axil.wready = w_wait >= cfg_w_lat; w_wait++;
               if (axil.wready) begin
                  last_wdata = axil.wdata; last_wstrb = axil.wstrb; last_wprot = axil.wprot;
                  w_cnt++; got_w = 1; w_wait = 0;
               end
            end else begin axil.wready = 0; w_wait = 0; end
            if (got_aw && got_w) begin b_pend = 1; got_aw = 0; got_w = 0; end
            if (axil.arvalid) begin
               axil.arready = ar_wait >= cfg_ar_lat; ar_wait++;
               if (axil.arready) begin
                  last_araddr = axil.araddr; last_arprot = axil.arprot; ar_cnt++; r_pend = 1; ar_wait = 0;
               end
            end else begin axil.arready = 0; ar_wait = 0; end
         end
      end
   end

   initial begin
      rsp.tready = 0;
      forever begin
         @(negedge clk);
         rsp.tready = sink_rnd ? 1'($urandom_range(0, 1)) : (sink_rdy && rsp_q.size() < stall_at);
         if (rsp.tvalid && rsp.tready) rsp_q.push_back({rsp.tlast, rsp.tdata});
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // response model: status byte then payload little-endian, tlast on the final byte
   function automatic logic [47:0] exp_rsp(input int n, input logic [39:0] b);
      logic [47:0] v = '0;
      v[47:45] = 3'(n);
      for (int i = 0; i < n; i++) v[9*i +: 9] = {i == n - 1, b[8*i +: 8]};
      return v;
   endfunction

   function automatic logic [47:0] got_rsp();
      logic [47:0] v = '0;
      v[47:45] = rsp_q.size() > 5 ? 3'd7 : 3'(rsp_q.size());
      for (int i = 0; i < rsp_q.size() && i < 5; i++) v[9*i +: 9] = rsp_q[i];
      return v;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      cmd.tdata = b; cmd.tvalid = 1;
      while (!cmd.tready && n < 300) begin @(negedge clk); n++; end
      if (n >= 300) begin checks++; failures++; $display("FAIL cmd_accept got=0 exp=1"); end
      @(negedge clk);
      cmd.tvalid = 0;
   endtask

   task automatic send_write(input logic [31:0] a, input logic [31:0] d);
      logic [63:0] f = {d, a};
      send_byte(8'h57);
      for (int i = 0; i < 8; i++) send_byte(f[8*i +: 8]);
   endtask

   task automatic send_read(input logic [31:0] a);
      send_byte(8'h52);
      for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
   endtask

   task automatic wait_rsp(input int n);
      int k = 0;
      while (rsp_q.size() < n && k < 400) begin @(negedge clk); k++; end
      if (k >= 400) begin checks++; failures++; $display("FAIL rsp_wait got=%0d exp=%0d", rsp_q.size(), n); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (3) @(negedge clk);
      rst = 0;
      @(negedge clk);
      checks++;
      if ({axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready, rsp.tvalid, busy} !== 7'b0) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=0", {axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready, rsp.tvalid, busy});
      end
      checks++;
      if (cmd.tready !== 1'b1) begin failures++; $display("FAIL reset_tready got=%b exp=1", cmd.tready); end
   endtask

   task automatic test_write();
      int lat = 1;
      logic [31:0] a, d;
      rsp_q.delete();
      send_write(32'h0, 32'h5);
      while (!rsp.tvalid && lat < 50) begin @(negedge clk); lat++; end
      checks++;
      if (lat !== 3) begin failures++; $display("FAIL wr_latency got=%0d exp=3", lat); end
      wait_rsp(1);
      checks++;
      if ({last_awaddr, last_wdata, last_wstrb, last_awprot, last_wprot} !== {32'h0, 32'h5, 4'hF, 6'b0}) begin
         failures++; $display("FAIL wr_axi got=%h %h %h exp=0 5 f", last_awaddr, last_wdata, last_wstrb);
      end
      checks++;
      if (got_rsp() !== exp_rsp(1, 40'h0)) begin failures++; $display("FAIL wr_rsp got=%h exp=%h", got_rsp(), exp_rsp(1, 40'h0)); end
      checks++;
      if ({rsp.tkeep, rsp.tid, rsp.tdest, rsp.tuser} !== 4'b1000) begin
         failures++; $display("FAIL rsp_sideband got=%b exp=1000", {rsp.tkeep, rsp.tid, rsp.tdest, rsp.tuser});
      end
      sink_rnd = 1;
      for (int i = 0; i < 6; i++) begin
         a = $urandom; d = $urandom;
         cfg_aw_lat = $urandom_range(0, 3); cfg_w_lat = $urandom_range(0, 3); cfg_bresp = 2'($urandom_range(0, 3));
         rsp_q.delete();
         send_write(a, d);
         wait_rsp(1);
         checks++;
         if ({last_awaddr, last_wdata, got_rsp()} !== {a, d, exp_rsp(1, {38'h0, cfg_bresp})}) begin
            failures++; $display("FAIL wr_rand got=%h %h %h exp=%h %h %h", last_awaddr, last_wdata, got_rsp(), a, d, exp_rsp(1, {38'h0, cfg_bresp}));
         end
      end
      sink_rnd = 0; cfg_aw_lat = 0; cfg_w_lat = 0; cfg_bresp = 0;
   endtask

   task automatic test_read();
      int lat = 1;
      logic [31:0] a;
      rsp_q.delete();
      cfg_rdata = 32'hA5A5_1234; cfg_rresp = 0;
      send_read(32'h8);
      while (!rsp.tvalid && lat < 50) begin @(negedge clk); lat++; end
      checks++;
      if (lat !== 3) begin failures++; $display("FAIL rd_latency got=%0d exp=3", lat); end
      wait_rsp(5);
      checks++;
      if ({last_araddr, last_arprot} !== {32'h8, 3'b0}) begin failures++; $display("FAIL rd_addr got=%h exp=8", last_araddr); end
      checks++;
      if (got_rsp() !== exp_rsp(5, {32'hA5A5_1234, 8'h00})) begin
         failures++; $display("FAIL rd_rsp got=%h exp=%h", got_rsp(), exp_rsp(5, {32'hA5A5_1234, 8'h00}));
      end
      sink_rnd = 1;
      for (int i = 0; i < 6; i++) begin
         a = $urandom; cfg_rdata = $urandom;
         cfg_ar_lat = $urandom_range(0, 3); cfg_rresp = 2'($urandom_range(0, 3));
         rsp_q.delete();
         send_read(a);
         wait_rsp(5);
         checks++;
         if ({last_araddr, got_rsp()} !== {a, exp_rsp(5, {cfg_rdata, 6'b0, cfg_rresp})}) begin
            failures++; $display("FAIL rd_rand got=%h %h exp=%h %h", last_araddr, got_rsp(), a, exp_rsp(5, {cfg_rdata, 6'b0, cfg_rresp}));
         end
      end
      sink_rnd = 0; cfg_ar_lat = 0; cfg_rresp = 0;
   endtask

   task automatic test_skew();
      logic [31:0] a = $urandom, d = $urandom;
      cfg_aw_lat = 0; cfg_w_lat = 3; cfg_bresp = 2'd2;
      rsp_q.delete();
      send_write(a, d);
      @(negedge clk);
      checks++;
      if ({axil.awvalid, axil.wvalid} !== 2'b01) begin failures++; $display("FAIL skew_valids got=%b exp=01", {axil.awvalid, axil.wvalid}); end
      wait_rsp(1);
      checks++;
      if ({last_awaddr, last_wdata, got_rsp()} !== {a, d, exp_rsp(1, 40'h2)}) begin
         failures++; $display("FAIL skew_rsp got=%h %h %h exp=%h %h %h", last_awaddr, last_wdata, got_rsp(), a, d, exp_rsp(1, 40'h2));
      end
      cfg_w_lat = 0; cfg_bresp = 0;
   endtask

   task automatic test_badop();
      logic [31:0] a = $urandom;
      rsp_q.delete();
      send_byte(8'h41);
      wait_rsp(1);
      checks++;
      if (got_rsp() !== exp_rsp(1, 40'hEE)) begin failures++; $display("FAIL badop_rsp got=%h exp=%h", got_rsp(), exp_rsp(1, 40'hEE)); end
      cfg_rdata = $urandom;
      rsp_q.delete();
      send_read(a);
      wait_rsp(5);
      checks++;
      if ({last_araddr, got_rsp()} !== {a, exp_rsp(5, {cfg_rdata, 8'h00})}) begin
         failures++; $display("FAIL badop_next got=%h %h exp=%h %h", last_araddr, got_rsp(), a, exp_rsp(5, {cfg_rdata, 8'h00}));
      end
   endtask

   task automatic test_timeout();
      int a0 = aw_cnt, w0 = w_cnt, r0 = ar_cnt;
      logic [31:0] a = $urandom, d = $urandom;
      rsp_q.delete();
      send_byte(8'h57);
      send_byte(8'h10);
      repeat (20) @(negedge clk);
      wait_rsp(1);
      checks++;
      if (got_rsp() !== exp_rsp(1, 40'hE0)) begin failures++; $display("FAIL timeout_rsp got=%h exp=%h", got_rsp(), exp_rsp(1, 40'hE0)); end
      checks++;
      if ({aw_cnt - a0, w_cnt - w0, ar_cnt - r0, 31'(busy)} !== '0) begin
         failures++; $display("FAIL timeout_axi got=%0d %0d %0d busy=%b exp=0 0 0 0", aw_cnt - a0, w_cnt - w0, ar_cnt - r0, busy);
      end
      rsp_q.delete();
      send_write(a, d);
      wait_rsp(1);
      checks++;
      if ({last_awaddr, last_wdata, got_rsp()} !== {a, d, exp_rsp(1, 40'h0)}) begin
         failures++; $display("FAIL timeout_next got=%h %h %h exp=%h %h", last_awaddr, last_wdata, got_rsp(), a, d);
      end
   endtask

   task automatic test_back_to_back();
      int kind;
      logic [31:0] a, d;
      logic [7:0] op;
      logic [47:0] e;
      sink_rnd = 1;
      for (int i = 0; i < 8; i++) begin
         kind = $urandom_range(0, 2); a = $urandom; d = $urandom;
         cfg_rdata = $urandom; cfg_bresp = 2'($urandom_range(0, 3)); cfg_rresp = 2'($urandom_range(0, 3));
         rsp_q.delete();
         if (kind == 0) begin send_write(a, d); e = exp_rsp(1, {38'h0, cfg_bresp}); wait_rsp(1); end
         else if (kind == 1) begin send_read(a); e = exp_rsp(5, {cfg_rdata, 6'b0, cfg_rresp}); wait_rsp(5); end
         else begin
            op = 8'($urandom);
            if (op == 8'h57 || op == 8'h52) op = 8'h00;
            send_byte(op); e = exp_rsp(1, 40'hEE); wait_rsp(1);
         end
         checks++;
         if (got_rsp() !== e) begin failures++; $display("FAIL b2b_kind%0d got=%h exp=%h", kind, got_rsp(), e); end
      end
      sink_rnd = 0; cfg_bresp = 0; cfg_rresp = 0;
   endtask

   task automatic test_backpressure_reset();
      int k = 0;
      logic [7:0] held;
      logic [31:0] a = $urandom, d = $urandom;
      cfg_rdata = $urandom;
      rsp_q.delete();
      stall_at = 2;
      send_read(a);
      while (rsp_q.size() < 2 && k < 100) begin @(negedge clk); k++; end
      @(negedge clk);
      held = rsp.tdata;
      checks++;
      if (held !== cfg_rdata[15:8]) begin failures++; $display("FAIL stall_byte got=%h exp=%h", held, cfg_rdata[15:8]); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if ({rsp.tvalid, rsp.tdata} !== {1'b1, held}) begin
            failures++; $display("FAIL stall_hold cyc=%0d got=%b %h exp=1 %h", i, rsp.tvalid, rsp.tdata, held);
         end
      end
      stall_at = 99;
      wait_rsp(5);
      checks++;
      if (got_rsp() !== exp_rsp(5, {cfg_rdata, 8'h00})) begin
         failures++; $display("FAIL stall_rsp got=%h exp=%h", got_rsp(), exp_rsp(5, {cfg_rdata, 8'h00}));
      end
      cfg_rhold = 1;
      rsp_q.delete();
      send_read(a);
      k = 0;
      while (!axil.rready && k < 100) begin @(negedge clk); k++; end
      rst = 1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready, rsp.tvalid, busy} !== 7'b0) begin
         failures++;
         $display("FAIL midrst_outputs got=%b exp=0", {axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready, rsp.tvalid, busy});
      end
      rst = 0; cfg_rhold = 0;
      @(negedge clk);
      checks++;
      if ({cmd.tready, busy} !== 2'b10) begin failures++; $display("FAIL midrst_ready got=%b exp=10", {cmd.tready, busy}); end
      rsp_q.delete();
      send_write(a, d);
      wait_rsp(1);
      checks++;
      if ({last_awaddr, last_wdata, got_rsp()} !== {a, d, exp_rsp(1, 40'h0)}) begin
         failures++; $display("FAIL midrst_next got=%h %h %h exp=%h %h", last_awaddr, last_wdata, got_rsp(), a, d);
      end
   endtask

   initial begin
      cmd.tvalid = 0; cmd.tdata = 0; cmd.tlast = 0; cmd.tkeep = 1; cmd.tid = 0; cmd.tdest = 0; cmd.tuser = 0;
      test_reset();
      test_write();
      test_read();
      test_skew();
      test_badop();
      test_timeout();
      test_back_to_back();
      test_backpressure_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
